// File: rtl/clk_switch_pkg.sv
// Shared constants for the N-input glitch-free clock switch.
// Contents: select FSM state encoding, legal parameter ranges and the
// wait-state timeout counter width helper.
`timescale 1ns/1ps
package clk_switch_pkg;

  // Select FSM state encoding
  localparam logic [1:0] ST_INIT     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_DIS_WAIT = 2'd2;
  localparam logic [1:0] ST_EN_WAIT  = 2'd3;

  // Legal parameter ranges
  localparam int unsigned NUM_CLK_MIN     = 2;
  localparam int unsigned NUM_CLK_MAX     = 8;
  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Counter width able to hold the value cyc itself (saturation point)
  function automatic int unsigned timeout_cnt_w(input int unsigned cyc);
    return $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/clk_switch_chan.sv
// One input channel of the clock switch.
// Ports: clk_i   - this channel's source clock
//        clka_i  - control clock (ack is returned into this domain)
//        rst_n   - asynchronous active-low reset
//        req_i   - gate request from the control domain
//        gclk_o  - gated clock (combinational clk_i & enable)
//        ack_o   - enable state synchronised into the control domain
`timescale 1ns/1ps
module clk_switch_chan #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic clka_i,
  input  logic rst_n,
  input  logic req_i,
  output logic gclk_o,
  output logic ack_o
);

  logic [SYNC_STAGES-1:0] fwd_q;
  logic [SYNC_STAGES-1:0] ack_q;
  logic                   en_q;

  // Request synchroniser into the channel's own domain
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) fwd_q <= '0;
    else        fwd_q <= {fwd_q[SYNC_STAGES-2:0], req_i};
  end

  // Enable changes on the falling edge so it only moves while clk_i is low
  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= fwd_q[SYNC_STAGES-1];
  end

  assign gclk_o = clk_i & en_q;

  // Enable state returned to the control domain
  always_ff @(posedge clka_i or negedge rst_n) begin
    if (!rst_n) ack_q <= '0;
    else        ack_q <= {ack_q[SYNC_STAGES-2:0], en_q};
  end

  assign ack_o = ack_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_switch_n.sv
// N-input glitch-free clock multiplexer with break-before-make switching.
// Ports: clka_n      - control clock, FSM on rising edge
//        rst_n       - asynchronous active-low reset, all domains
//        clk_in      - source clocks
//        sel_req     - requested channel, sel_valid/sel_ready handshake
//        cur_sel     - channel currently driving clkout
//        busy        - switch in progress
//        sel_err     - one-cycle pulse on out-of-range request
//        timeout_err - sticky wait-state timeout, cleared on entry to RUN
//        clkout      - muxed clock
`timescale 1ns/1ps
module clk_switch_n
  import clk_switch_pkg::*;
#(
  parameter int unsigned NUM_CLK     = 4,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEFAULT_SEL = 0,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clka_n,
  input  logic               rst_n,
  input  logic [NUM_CLK-1:0] clk_in,
  input  logic [SEL_W-1:0]   sel_req,
  input  logic               sel_valid,
  output logic               sel_ready,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               busy,
  output logic               sel_err,
  output logic               timeout_err,
  output logic               clkout
);

  localparam int unsigned      CNT_W    = timeout_cnt_w(TIMEOUT_CYC);
  localparam logic [SEL_W-1:0] DEF_SEL  = SEL_W'(DEFAULT_SEL);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]         state_q, state_d;
  logic [SEL_W-1:0]   tgt_q, tgt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic [NUM_CLK-1:0] gate_req_q, gate_req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               sel_ready_q, sel_ready_d;
  logic               sel_err_q, sel_err_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_CLK-1:0] ack;
  logic [NUM_CLK-1:0] gclk;
  logic               ack_cur_c;
  logic               ack_tgt_c;
  logic               req_oob_c;

  // Select-to-one-hot without indexing past NUM_CLK
  function automatic logic [NUM_CLK-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [NUM_CLK-1:0] oh;
    oh = '0;
    for (int unsigned i = 0; i < NUM_CLK; i++) begin
      if (SEL_W'(i) == s) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  assign ack_cur_c = |(ack & onehot(cur_sel_q));
  assign ack_tgt_c = |(ack & onehot(tgt_q));
  assign req_oob_c = 32'(sel_req) >= 32'(NUM_CLK);

  // Per-channel synchronisers and clock gates
  for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
    clk_switch_chan #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_chan (
      .clk_i (clk_in[g]),
      .clka_i(clka_n),
      .rst_n (rst_n),
      .req_i (gate_req_q[g]),
      .gclk_o(gclk[g]),
      .ack_o (ack[g])
    );
  end

  assign clkout = |gclk;

  // Select FSM next state and registered-output next values
  always_comb begin
    state_d       = state_q;
    tgt_d         = tgt_q;
    cur_sel_d     = cur_sel_q;
    gate_req_d    = gate_req_q;
    cnt_d         = cnt_q;
    sel_err_d     = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_INIT: begin
        tgt_d      = DEF_SEL;
        gate_req_d = onehot(DEF_SEL);
        cnt_d      = '0;
        state_d    = ST_EN_WAIT;
      end
      ST_RUN: begin
        if (sel_valid && sel_ready_q) begin
          if (req_oob_c) begin
            sel_err_d = 1'b1;
          end else if (sel_req != cur_sel_q) begin
            tgt_d      = sel_req;
            gate_req_d = '0;
            cnt_d      = '0;
            state_d    = ST_DIS_WAIT;
          end
        end
      end
      ST_DIS_WAIT: begin
        gate_req_d = '0;
        if (!ack_cur_c) begin
          // Old channel confirmed off: only now request the new one
          gate_req_d = onehot(tgt_q);
          cnt_d      = '0;
          state_d    = ST_EN_WAIT;
        end else begin
          if (cnt_q < CNT_MAX)   cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_LAST) timeout_err_d = 1'b1;
        end
      end
      ST_EN_WAIT: begin
        gate_req_d = onehot(tgt_q);
        if (ack_tgt_c) begin
          cur_sel_d     = tgt_q;
          timeout_err_d = 1'b0;
          state_d       = ST_RUN;
        end else begin
          if (cnt_q < CNT_MAX)   cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q >= CNT_LAST) timeout_err_d = 1'b1;
        end
      end
      default: begin
        gate_req_d = '0;
        state_d    = ST_INIT;
      end
    endcase

    busy_d      = (state_d != ST_RUN);
    sel_ready_d = (state_d == ST_RUN);
  end

  // Control-domain state register
  always_ff @(posedge clka_n or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      tgt_q         <= DEF_SEL;
      cur_sel_q     <= DEF_SEL;
      gate_req_q    <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b1;
      sel_ready_q   <= 1'b0;
      sel_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      cur_sel_q     <= cur_sel_d;
      gate_req_q    <= gate_req_d;
      cnt_q         <= cnt_d;
      busy_q        <= busy_d;
      sel_ready_q   <= sel_ready_d;
      sel_err_q     <= sel_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign sel_ready   = sel_ready_q;
  assign cur_sel     = cur_sel_q;
  assign busy        = busy_q;
  assign sel_err     = sel_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clk_switch_n.sv
// Directed bench for clk_switch_n: reset, switching, no-op and
// out-of-range requests, dead-clock timeout and reset mid-switch.
`timescale 1ns/1ps
module tb_clk_switch_n;

  localparam int unsigned NUM_CLK = 4;
  localparam int unsigned SEL_W   = 3;

  logic clka_n = 1'b0;
  logic rst_n  = 1'b0;
  logic clk0 = 1'b0, clk1 = 1'b0, clk2 = 1'b0, clk3 = 1'b0;
  logic [3:0] run = 4'hF;
  logic [NUM_CLK-1:0] clk_in;
  logic [SEL_W-1:0] sel_req = '0;
  logic sel_valid = 1'b0;
  logic sel_ready, busy, sel_err, timeout_err, clkout;
  logic [SEL_W-1:0] cur_sel;

  int errors = 0;
  int checks = 0;

  // clka 50 MHz; sources 100 / 75 / 50 / 33 MHz, parked low when stopped
  always #10.0  clka_n = ~clka_n;
  always #5.0   clk0 = run[0] ? ~clk0 : 1'b0;
  always #6.667 clk1 = run[1] ? ~clk1 : 1'b0;
  always #10.0  clk2 = run[2] ? ~clk2 : 1'b0;
  always #15.0  clk3 = run[3] ? ~clk3 : 1'b0;
  assign clk_in = {clk3, clk2, clk1, clk0};

  clk_switch_n #(
    .NUM_CLK    (NUM_CLK),
    .SEL_W      (SEL_W),
    .SYNC_STAGES(2),
    .DEFAULT_SEL(0),
    .TIMEOUT_CYC(1024)
  ) dut (
    .clka_n     (clka_n),
    .rst_n      (rst_n),
    .clk_in     (clk_in),
    .sel_req    (sel_req),
    .sel_valid  (sel_valid),
    .sel_ready  (sel_ready),
    .cur_sel    (cur_sel),
    .busy       (busy),
    .sel_err    (sel_err),
    .timeout_err(timeout_err),
    .clkout     (clkout)
  );

  // clkout pulse-width and low-gap monitor
  bit      mon_en = 1'b0;
  int      glitches = 0;
  int      twohot = 0;
  realtime last_edge = 0.0;
  realtime last_fall = 0.0;
  realtime max_low = 0.0;

  always @(clkout) begin
    if (mon_en && ($realtime - last_edge) < 4.5) glitches++;
    if (clkout === 1'b1 && mon_en && ($realtime - last_fall) > max_low)
      max_low = $realtime - last_fall;
    if (clkout === 1'b0) last_fall = $realtime;
    last_edge = $realtime;
  end

  always @(negedge clka_n) begin
    if ($countones(dut.gate_req_q) > 1) twohot++;
  end

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clka_n);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Present a request for one clka cycle, return on the negedge after accept
  task automatic do_req(input logic [SEL_W-1:0] s);
    @(negedge clka_n);
    sel_req   = s;
    sel_valid = 1'b1;
    @(negedge clka_n);
    sel_valid = 1'b0;
  endtask

  task automatic test_reset;
    bit ok;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk0); #1;
      checks++;
      if (clkout !== 1'b0) begin errors++; $display("FAIL reset_clkout: got %b want 0", clkout); end
    end
    @(negedge clka_n);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++;
    if (sel_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", sel_ready); end
    checks++;
    if (sel_err !== 1'b0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL reset_errs: got sel_err=%b timeout_err=%b want 0 0", sel_err, timeout_err);
    end
    checks++;
    if (cur_sel !== 3'd0) begin errors++; $display("FAIL reset_cur_sel: got %0d want 0", cur_sel); end
    rst_n = 1'b1;
    wait_idle(10, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_busy_timeout: busy=%b after 10 cycles want 0", busy); end
    checks++;
    if (sel_ready !== 1'b1 || cur_sel !== 3'd0) begin
      errors++; $display("FAIL init_state: got ready=%b cur_sel=%0d want 1 0", sel_ready, cur_sel);
    end
    @(posedge clk0); #1;
    checks++;
    if (clkout !== 1'b1) begin errors++; $display("FAIL init_follow_hi: got %b want 1", clkout); end
    @(negedge clk0); #1;
    checks++;
    if (clkout !== 1'b0) begin errors++; $display("FAIL init_follow_lo: got %b want 0", clkout); end
  endtask

  task automatic test_switch;
    bit ok;
    glitches = 0; twohot = 0; max_low = 0.0; mon_en = 1'b1;
    do_req(3'd2);
    checks++;
    if (busy !== 1'b1 || sel_ready !== 1'b0) begin
      errors++; $display("FAIL switch_busy: got busy=%b ready=%b want 1 0", busy, sel_ready);
    end
    wait_idle(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL switch_done_timeout: busy=%b want 0", busy); end
    checks++;
    if (cur_sel !== 3'd2) begin errors++; $display("FAIL switch_cur_sel: got %0d want 2", cur_sel); end
    checks++;
    if (glitches != 0) begin errors++; $display("FAIL switch_glitch: got %0d short pulses want 0", glitches); end
    checks++;
    if (twohot != 0) begin errors++; $display("FAIL switch_twohot: got %0d cycles want 0", twohot); end
    checks++;
    if (!(max_low >= 20.0)) begin errors++; $display("FAIL switch_gap: got %0t ns low want >= 20", max_low); end
    @(posedge clk2); #1;
    checks++;
    if (clkout !== 1'b1) begin errors++; $display("FAIL switch_follow_hi: got %b want 1", clkout); end
    @(negedge clk2); #1;
    checks++;
    if (clkout !== 1'b0) begin errors++; $display("FAIL switch_follow_lo: got %b want 0", clkout); end
  endtask

  task automatic test_same_sel;
    glitches = 0; max_low = 0.0;
    do_req(3'd2);
    checks++;
    if (busy !== 1'b0 || sel_ready !== 1'b1 || cur_sel !== 3'd2) begin
      errors++; $display("FAIL same_sel_state: got busy=%b ready=%b cur_sel=%0d want 0 1 2", busy, sel_ready, cur_sel);
    end
    repeat (10) @(negedge clka_n);
    checks++;
    if (glitches != 0 || max_low > 10.5) begin
      errors++; $display("FAIL same_sel_uninterrupted: got glitches=%0d max_low=%0t want 0 <=10.5", glitches, max_low);
    end
    mon_en = 1'b0;
  endtask

  task automatic test_sel_err;
    @(negedge clka_n);
    sel_req = 3'd5;
    sel_valid = 1'b1;
    @(negedge clka_n);
    sel_valid = 1'b0;
    checks++;
    if (sel_err !== 1'b1) begin errors++; $display("FAIL sel_err_pulse: got %b want 1", sel_err); end
    checks++;
    if (cur_sel !== 3'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL sel_err_state: got cur_sel=%0d busy=%b want 2 0", cur_sel, busy);
    end
    @(negedge clka_n);
    checks++;
    if (sel_err !== 1'b0 || sel_ready !== 1'b1) begin
      errors++; $display("FAIL sel_err_width: got sel_err=%b ready=%b want 0 1", sel_err, sel_ready);
    end
  endtask

  task automatic test_timeout;
    run[2] = 1'b0;
    repeat (3) @(negedge clka_n);
    do_req(3'd1);
    repeat (1023) @(negedge clka_n);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", timeout_err); end
    @(negedge clka_n);
    checks++;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_set: got %b want 1", timeout_err); end
    checks++;
    if (busy !== 1'b1 || clkout !== 1'b0 || cur_sel !== 3'd2) begin
      errors++; $display("FAIL timeout_state: got busy=%b clkout=%b cur_sel=%0d want 1 0 2", busy, clkout, cur_sel);
    end
  endtask

  task automatic test_reset_mid_switch;
    bit ok;
    run[2] = 1'b1;
    wait_idle(200, ok);
    checks++;
    if (!ok || cur_sel !== 3'd1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL resume_state: got idle=%b cur_sel=%0d timeout_err=%b want 1 1 0", ok, cur_sel, timeout_err);
    end
    do_req(3'd3);
    @(posedge clk1); #1;
    checks++;
    if (clkout !== 1'b1) begin errors++; $display("FAIL midsw_pre: got clkout=%b want 1", clkout); end
    rst_n = 1'b0;
    #0.5;
    checks++;
    if (clkout !== 1'b0) begin errors++; $display("FAIL midsw_clkout: got %b want 0", clkout); end
    checks++;
    if (busy !== 1'b1 || sel_ready !== 1'b0 || cur_sel !== 3'd0) begin
      errors++; $display("FAIL midsw_regs: got busy=%b ready=%b cur_sel=%0d want 1 0 0", busy, sel_ready, cur_sel);
    end
    repeat (3) @(negedge clka_n);
    rst_n = 1'b1;
    wait_idle(10, ok);
    checks++;
    if (!ok || cur_sel !== 3'd0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL midsw_restore: got idle=%b cur_sel=%0d timeout_err=%b want 1 0 0", ok, cur_sel, timeout_err);
    end
    @(posedge clk0); #1;
    checks++;
    if (clkout !== 1'b1) begin errors++; $display("FAIL midsw_follow: got %b want 1", clkout); end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_switch();
    test_same_sel();
    test_sel_err();
    test_timeout();
    test_reset_mid_switch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
